// File: rtl/trivium_init_ctrl.sv
// trivium_init_ctrl: key/IV capture, initial register images and load/warm-up/run sequencing for a Trivium core.
// Optional TRIVIUM_INIT_CTRL_KS_COUNT_EN adds a saturating ks_count output.
module trivium_init_ctrl #(
    parameter int WARMUP_CYCLES = 1152,
    parameter int CNT_WIDTH     = $clog2(WARMUP_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [79:0]  key,
    input  logic [79:0]  iv,
    output logic         load,
    output logic         shift_right,
    output logic [92:0]  din_a,
    output logic [83:0]  din_b,
    output logic [110:0] din_c,
    output logic         busy,
    output logic         ks_ready,
    input  logic         ks_req,
    output logic         ks_valid
`ifdef TRIVIUM_INIT_CTRL_KS_COUNT_EN
   ,output logic [31:0]  ks_count
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;
    localparam logic [CNT_WIDTH-1:0] W_LAST = CNT_WIDTH'(WARMUP_CYCLES - 1);
    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [79:0]          r_key, r_iv;
    logic                 r_ks_valid;
    logic                 w_accept;
    assign w_accept = start && (r_state == IDLE || r_state == RUN);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_key      <= '0;
            r_iv       <= '0;
            r_ks_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= (r_state == LOAD) ? '0 : (r_state == WARMUP) ? r_cnt + CNT_WIDTH'(1) : r_cnt;
            r_key      <= w_accept ? key : r_key;
            r_iv       <= w_accept ? iv : r_iv;
            // The core registers output_bit, so a RUN request shows up as valid one cycle later
            r_ks_valid <= ks_req && (r_state == RUN);
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? LOAD : IDLE;
            LOAD:    w_state_nxt = WARMUP;
            WARMUP:  w_state_nxt = (r_cnt == W_LAST) ? RUN : WARMUP;
            RUN:     w_state_nxt = start ? LOAD : RUN;
            default: w_state_nxt = IDLE;
        endcase
    end
    assign load        = (r_state == LOAD);
    assign shift_right = (r_state == WARMUP) || (r_state == RUN && ks_req);
    assign busy        = (r_state == LOAD) || (r_state == WARMUP);
    assign ks_ready    = (r_state == RUN);
    assign ks_valid    = r_ks_valid;
    assign din_a       = {r_key, 13'd0};
    assign din_b       = {r_iv, 4'd0};
    assign din_c       = {108'd0, 3'b111};
`ifdef TRIVIUM_INIT_CTRL_KS_COUNT_EN
    logic [31:0] r_ks_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ks_count <= '0;
        else
            r_ks_count <= (r_state == LOAD) ? '0 : (r_ks_valid && r_ks_count != 32'hFFFF_FFFF) ? r_ks_count + 32'd1 : r_ks_count;
    end
    assign ks_count = r_ks_count;
`endif
endmodule

// File: tb/tb_trivium_init_ctrl.sv
// tb_trivium_init_ctrl: directed bench with a behavioural Trivium core and an independent golden keystream model.
module tb_trivium_init_ctrl;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, ks_req = 1'b0;
    logic [79:0]  key = '0, iv = '0;
    logic         load, shift_right, busy, ks_ready, ks_valid;
    logic [92:0]  din_a;
    logic [83:0]  din_b;
    logic [110:0] din_c;
`ifdef TRIVIUM_INIT_CTRL_KS_COUNT_EN
    logic [31:0]  ks_count;
`endif
    int n_checks = 0, n_fail = 0;

    trivium_init_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .iv(iv),
        .load(load), .shift_right(shift_right), .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .busy(busy), .ks_ready(ks_ready), .ks_req(ks_req), .ks_valid(ks_valid)
`ifdef TRIVIUM_INIT_CTRL_KS_COUNT_EN
       ,.ks_count(ks_count)
`endif
    );

    always #5 clk = ~clk;

    // Three shift registers of the core, MSB = lowest state index
    logic [92:0]  a;
    logic [83:0]  b;
    logic [110:0] c;
    logic         out_bit;
    logic         t1, t2, t3;
    assign t1 = a[27] ^ a[0];
    assign t2 = b[15] ^ b[0];
    assign t3 = c[45] ^ c[0];
    always @(posedge clk) begin
        if (load) begin
            a <= din_a;
            b <= din_b;
            c <= din_c;
        end else if (shift_right) begin
            a       <= {t3 ^ (c[2] & c[1]) ^ a[24], a[92:1]};
            b       <= {t1 ^ (a[2] & a[1]) ^ b[6], b[83:1]};
            c       <= {t2 ^ (b[2] & b[1]) ^ c[24], c[110:1]};
            out_bit <= t1 ^ t2 ^ t3;
        end
    end

    function automatic logic [63:0] golden(input logic [79:0] k, input logic [79:0] v);
        logic [288:1] s;
        logic         g1, g2, g3;
        logic [63:0]  z;
        s = '0;
        z = '0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[80-i];
            s[93 + i] = v[80-i];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int n = 0; n < 1152 + 64; n++) begin
            g1 = s[66] ^ s[93];
            g2 = s[162] ^ s[177];
            g3 = s[243] ^ s[288];
            if (n >= 1152) z[n-1152] = g1 ^ g2 ^ g3;
            g1 = g1 ^ (s[91] & s[92]) ^ s[171];
            g2 = g2 ^ (s[175] & s[176]) ^ s[264];
            g3 = g3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 2; i--) s[i] = s[i-1];
            s[1] = g3; s[94] = g1; s[178] = g2;
        end
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if ({load, shift_right, busy, ks_ready, ks_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {load, shift_right, busy, ks_ready, ks_valid}); end
        n_checks++; if (din_a !== '0 || din_b !== '0) begin n_fail++; $display("FAIL reset_din_ab: got %h %h expected 0 0", din_a, din_b); end
        n_checks++; if (din_c !== 111'd7) begin n_fail++; $display("FAIL reset_din_c: got %h expected 7", din_c); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({load, shift_right, busy} !== 3'b0) begin n_fail++; $display("FAIL idle_quiet: got %b expected 000", {load, shift_right, busy}); end
    endtask

    task automatic test_zero_init();
        int shifts = 0, bad = 0;
        key = '0; iv = '0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({load, shift_right, busy} !== 3'b101) begin n_fail++; $display("FAIL zero_load_cycle: got %b expected 101", {load, shift_right, busy}); end
        n_checks++; if (din_c[2:0] !== 3'b111 || din_a !== '0 || din_b !== '0) begin n_fail++; $display("FAIL zero_images: got a=%h b=%h c=%h", din_a, din_b, din_c); end
        for (int cyc = 2; cyc <= 1153; cyc++) begin
            tick();
            shifts += int'(shift_right);
            if (load || !busy || ks_ready) bad++;
        end
        n_checks++; if (shifts !== 1152) begin n_fail++; $display("FAIL zero_shift_count: got %0d expected 1152", shifts); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL zero_warmup_flags: got %0d bad cycles expected 0", bad); end
        tick();
        n_checks++; if ({ks_ready, busy, shift_right} !== 3'b100) begin n_fail++; $display("FAIL zero_ready_1154: got %b expected 100", {ks_ready, busy, shift_right}); end
    endtask

    task automatic test_image();
        logic [92:0] exp_a;
        exp_a = 93'd1 << 92;
        key = 80'h8000_0000_0000_0000_0000; iv = 80'h1; start = 1'b1;
        tick();
        start = 1'b0;
        key = '1; iv = '1;
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL image_rekey_load: got %b expected 1", load); end
        n_checks++; if (din_a !== exp_a) begin n_fail++; $display("FAIL image_din_a: got %h expected %h", din_a, exp_a); end
        n_checks++; if (din_b !== 84'h10) begin n_fail++; $display("FAIL image_din_b: got %h expected 10", din_b); end
        tick();
        n_checks++; if (din_a !== exp_a || din_b !== 84'h10) begin n_fail++; $display("FAIL image_hold: got %h %h expected %h 10", din_a, din_b, exp_a); end
        for (int i = 0; i < 1300 && !ks_ready; i++) tick();
        n_checks++; if (ks_ready !== 1'b1) begin n_fail++; $display("FAIL image_ready_timeout: got %b expected 1", ks_ready); end
    endtask

    task automatic test_keystream();
        logic [63:0] g;
        int bad = 0;
        key = 80'h0123_4567_89AB_CDEF_1357; iv = 80'hFEDC_BA98_7654_3210_2468;
        g = golden(key, iv);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1300 && !ks_ready; i++) tick();
        n_checks++; if (ks_ready !== 1'b1) begin n_fail++; $display("FAIL ks_ready_timeout: got %b expected 1", ks_ready); end
        ks_req = 1'b1;
        #1;
        n_checks++; if (shift_right !== 1'b1) begin n_fail++; $display("FAIL ks_comb_shift: got %b expected 1", shift_right); end
        for (int i = 0; i < 64; i++) begin
            tick();
            if (i == 63) ks_req = 1'b0;
            if (ks_valid !== 1'b1 || out_bit !== g[i]) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ks_stream: got %0d bad bits expected 0", bad); end
        tick();
        n_checks++; if (ks_valid !== 1'b0) begin n_fail++; $display("FAIL ks_valid_drop: got %b expected 0", ks_valid); end
    endtask

    task automatic test_rekey();
        ks_req = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({load, ks_valid, shift_right} !== 3'b110) begin n_fail++; $display("FAIL rekey_load_cycle: got %b expected 110", {load, ks_valid, shift_right}); end
        tick();
        ks_req = 1'b0;
        n_checks++; if (ks_valid !== 1'b0) begin n_fail++; $display("FAIL rekey_drop_req: got %b expected 0", ks_valid); end
        for (int i = 0; i < 1300 && !ks_ready; i++) tick();
        n_checks++; if (ks_ready !== 1'b1) begin n_fail++; $display("FAIL rekey_ready_timeout: got %b expected 1", ks_ready); end
    endtask

    task automatic test_start_ignored();
        int bad = 0;
        ks_req = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ks_req = 1'b1;
        n_checks++; if ({load, shift_right} !== 2'b10) begin n_fail++; $display("FAIL ign_load_req: got %b expected 10", {load, shift_right}); end
        for (int cyc = 2; cyc <= 1153; cyc++) begin
            tick();
            ks_req = cyc[0];
            start = (cyc == 500);
            if (!shift_right || load || ks_valid || ks_ready) bad++;
        end
        start = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ign_warmup: got %0d bad cycles expected 0", bad); end
        tick();
        ks_req = 1'b0;
        n_checks++; if ({ks_ready, ks_valid} !== 2'b10) begin n_fail++; $display("FAIL ign_ready_1154: got %b expected 10", {ks_ready, ks_valid}); end
    endtask

    task automatic test_reset_mid();
        int shifts = 0, bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 2; cyc <= 700; cyc++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if ({load, shift_right, busy, ks_ready, ks_valid} !== 5'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 00000", {load, shift_right, busy, ks_ready, ks_valid}); end
        n_checks++; if (din_a !== '0 || din_b !== '0) begin n_fail++; $display("FAIL midrst_din: got %h %h expected 0 0", din_a, din_b); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (shift_right || busy || load) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_idle: got %0d bad cycles expected 0", bad); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL midrst_load: got %b expected 1", load); end
        bad = 0;
        for (int cyc = 2; cyc <= 1153; cyc++) begin
            tick();
            shifts += int'(shift_right);
            if (ks_ready) bad++;
        end
        n_checks++; if (shifts !== 1152 || bad !== 0) begin n_fail++; $display("FAIL midrst_warmup: got %0d shifts %0d early ready expected 1152 0", shifts, bad); end
        tick();
        n_checks++; if (ks_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ks_ready); end
    endtask

`ifdef TRIVIUM_INIT_CTRL_KS_COUNT_EN
    task automatic test_ks_count();
        ks_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ks_req = 1'b0;
        tick();
        n_checks++; if (ks_count !== 32'd10) begin n_fail++; $display("FAIL cnt_ten: got %0d expected 10", ks_count); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (ks_count !== 32'd10) begin n_fail++; $display("FAIL cnt_in_load: got %0d expected 10", ks_count); end
        tick();
        n_checks++; if (ks_count !== 32'd0) begin n_fail++; $display("FAIL cnt_cleared: got %0d expected 0", ks_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_init();
        test_image();
        test_keystream();
        test_rekey();
        test_start_ignored();
        test_reset_mid();
`ifdef TRIVIUM_INIT_CTRL_KS_COUNT_EN
        test_ks_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
